// File: rtl/regfile_port_arbiter_pkg.sv
// Shared widths and FSM encodings for the register-file port arbiter.
package regfile_port_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_e;
endpackage

// File: rtl/regfile_port_arbiter_starve_counter.sv
// Saturating count of consecutive ungranted debug-request cycles.
module starve_counter #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign at_limit = (r_cnt == LIM);
endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register-file write port and read port 2 between the pipeline
// and a debug/loader port; zero-fills the register file after reset or on request.
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int NUM_REGS     = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  WB_RegWrite,
  input  logic [REG_ADDR_W-1:0] WB_WriteRegister,
  input  logic [REG_DATA_W-1:0] WB_WriteData,
  input  logic [REG_ADDR_W-1:0] ID_ReadRegister2,
  input  logic                  ID_ReadEn2,
  input  logic                  Clear_Start,
  input  logic                  Dbg_Req,
  input  logic                  Dbg_We,
  input  logic [REG_ADDR_W-1:0] Dbg_Addr,
  input  logic [REG_DATA_W-1:0] Dbg_WData,
  input  logic [REG_DATA_W-1:0] ReadData2,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteRegister,
  output logic [REG_DATA_W-1:0] WriteData,
  output logic [REG_ADDR_W-1:0] ReadRegister2,
  output logic                  Stall,
  output logic                  Dbg_Ack,
  output logic [REG_DATA_W-1:0] Dbg_RData,
  output logic                  Clear_Done
);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

  arb_state_e            r_state;
  logic [REG_ADDR_W-1:0] r_clr_idx;
  logic [REG_DATA_W-1:0] r_dbg_rdata;

  logic w_idle;
  logic w_eligible;
  logic w_at_limit;
  logic w_grant;
  logic w_forced;

  // Debug handshake: Dbg_Req with its Dbg_* payload is held by the requester
  // until the single-cycle Dbg_Ack, which always follows the grant cycle.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_eligible = Dbg_Req && (Dbg_We ? !WB_RegWrite : !ID_ReadEn2);
  assign w_grant    = w_idle && !Clear_Start && (w_eligible || (Dbg_Req && w_at_limit));
  assign w_forced   = w_grant && !w_eligible;

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .inc      (w_idle && Dbg_Req && !w_grant),
    .clr      (w_grant || !Dbg_Req),
    .at_limit (w_at_limit)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= ST_CLEAR;
      r_clr_idx   <= '0;
      r_dbg_rdata <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_idx == LAST_IDX) begin
            r_state   <= ST_IDLE;
            r_clr_idx <= '0;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        ST_IDLE: begin
          if (Clear_Start) begin
            r_state <= ST_CLEAR;
          end else if (w_grant) begin
            r_state <= ST_ACK;
            if (!Dbg_We) r_dbg_rdata <= ReadData2;
          end
        end
        ST_ACK:  r_state <= Clear_Start ? ST_CLEAR : ST_IDLE;
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  always_comb begin
    RegWrite      = WB_RegWrite;
    WriteRegister = WB_WriteRegister;
    WriteData     = WB_WriteData;
    ReadRegister2 = ID_ReadRegister2;
    Stall         = 1'b0;
    if (r_state == ST_CLEAR) begin
      RegWrite      = 1'b1;
      WriteRegister = r_clr_idx;
      WriteData     = '0;
      Stall         = 1'b1;
    end else if (w_grant) begin
      if (Dbg_We) begin
        RegWrite      = 1'b1;
        WriteRegister = Dbg_Addr;
        WriteData     = Dbg_WData;
      end else begin
        ReadRegister2 = Dbg_Addr;
      end
      // A forced grant holds the pipeline, so its WB write must not land now.
      if (w_forced) begin
        Stall = 1'b1;
        if (!Dbg_We) RegWrite = 1'b0;
      end
    end
  end

  assign Dbg_Ack    = (r_state == ST_ACK);
  assign Dbg_RData  = r_dbg_rdata;
  assign Clear_Done = w_idle;
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural register file behind it.
module tb_regfile_port_arbiter;
  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteRegister;
  logic [31:0] WB_WriteData;
  logic [4:0]  ID_ReadRegister2;
  logic        ID_ReadEn2;
  logic        Clear_Start;
  logic        Dbg_Req;
  logic        Dbg_We;
  logic [4:0]  Dbg_Addr;
  logic [31:0] Dbg_WData;
  logic [31:0] ReadData2;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister2;
  logic        Stall;
  logic        Dbg_Ack;
  logic [31:0] Dbg_RData;
  logic        Clear_Done;

  int n_vec = 0;
  int n_err = 0;

  logic        fill;
  logic [31:0] rf [32];

  always #5 Clk = ~Clk;

  // Register file model; "fill" preloads non-zero junk so the clear is visible.
  always @(posedge Clk) begin
    if (fill) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hA5A50000 | 32'(i);
    end else if (RegWrite) begin
      rf[WriteRegister] <= WriteData;
    end
  end
  assign ReadData2 = rf[ReadRegister2];

  regfile_port_arbiter #(.STARVE_LIMIT(8), .NUM_REGS(32)) dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .WB_RegWrite      (WB_RegWrite),
    .WB_WriteRegister (WB_WriteRegister),
    .WB_WriteData     (WB_WriteData),
    .ID_ReadRegister2 (ID_ReadRegister2),
    .ID_ReadEn2       (ID_ReadEn2),
    .Clear_Start      (Clear_Start),
    .Dbg_Req          (Dbg_Req),
    .Dbg_We           (Dbg_We),
    .Dbg_Addr         (Dbg_Addr),
    .Dbg_WData        (Dbg_WData),
    .ReadData2        (ReadData2),
    .RegWrite         (RegWrite),
    .WriteRegister    (WriteRegister),
    .WriteData        (WriteData),
    .ReadRegister2    (ReadRegister2),
    .Stall            (Stall),
    .Dbg_Ack          (Dbg_Ack),
    .Dbg_RData        (Dbg_RData),
    .Clear_Done       (Clear_Done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst_n = 1'b0; fill = 1'b1;
    WB_RegWrite = 1'b0; WB_WriteRegister = '0; WB_WriteData = '0;
    ID_ReadRegister2 = '0; ID_ReadEn2 = 1'b0; Clear_Start = 1'b0;
    Dbg_Req = 1'b0; Dbg_We = 1'b0; Dbg_Addr = '0; Dbg_WData = '0;
    repeat (3) @(negedge Clk);
    fill = 1'b0;
    #1;
    chk("rst_stall", 32'(Stall), 32'd1);
    chk("rst_regwrite", 32'(RegWrite), 32'd1);
    chk("rst_wreg", 32'(WriteRegister), 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_clear_done", 32'(Clear_Done), 32'd0);
    chk("rst_ack", 32'(Dbg_Ack), 32'd0);
    chk("rst_rdata", Dbg_RData, 32'd0);

    // Clear sequence after reset release: indices 0..31, one per cycle.
    @(negedge Clk); Rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("clr_wreg", 32'(WriteRegister), 32'(i));
      chk("clr_we_stall", {30'd0, RegWrite, Stall}, 32'd3);
      chk("clr_wdata", WriteData, 32'd0);
      @(negedge Clk);
    end
    ID_ReadRegister2 = 5'd8; ID_ReadEn2 = 1'b1; #1;
    chk("clear_done", 32'(Clear_Done), 32'd1);
    chk("rd_reg8", ReadData2, 32'd0);

    // WB write reg9 while debug write reg10 waits for WB_RegWrite=0.
    @(negedge Clk);
    WB_RegWrite = 1'b1; WB_WriteRegister = 5'd9; WB_WriteData = 32'h1234;
    Dbg_Req = 1'b1; Dbg_We = 1'b1; Dbg_Addr = 5'd10; Dbg_WData = 32'hBEEF; #1;
    chk("wb_pass_wreg", 32'(WriteRegister), 32'd9);
    chk("wb_pass_wdata", WriteData, 32'h1234);
    chk("wb_pass_stall", 32'(Stall), 32'd0);
    chk("wb_pass_ack", 32'(Dbg_Ack), 32'd0);
    @(negedge Clk);
    WB_RegWrite = 1'b0; #1;
    chk("dbgw_grant_we", 32'(RegWrite), 32'd1);
    chk("dbgw_grant_wreg", 32'(WriteRegister), 32'd10);
    chk("dbgw_grant_wdata", WriteData, 32'hBEEF);
    chk("dbgw_grant_ack", 32'(Dbg_Ack), 32'd0);
    @(negedge Clk); #1;
    chk("dbgw_ack", 32'(Dbg_Ack), 32'd1);
    Dbg_Req = 1'b0;
    @(negedge Clk);
    ID_ReadRegister2 = 5'd10; #1;
    chk("dbgw_ack_drop", 32'(Dbg_Ack), 32'd0);
    chk("rd_reg10", ReadData2, 32'hBEEF);

    // Debug read of reg9 with read port 2 free.
    @(negedge Clk);
    ID_ReadEn2 = 1'b0; ID_ReadRegister2 = 5'd3;
    Dbg_Req = 1'b1; Dbg_We = 1'b0; Dbg_Addr = 5'd9; #1;
    chk("dbgr_raddr", 32'(ReadRegister2), 32'd9);
    @(negedge Clk); #1;
    chk("dbgr_ack", 32'(Dbg_Ack), 32'd1);
    chk("dbgr_rdata", Dbg_RData, 32'h1234);
    chk("dbgr_raddr_pass", 32'(ReadRegister2), 32'd3);
    Dbg_Req = 1'b0;

    // Starvation: WB keeps writing; forced grant on the 9th request cycle.
    @(negedge Clk);
    WB_RegWrite = 1'b1; WB_WriteRegister = 5'd11; WB_WriteData = 32'h1111;
    Dbg_Req = 1'b1; Dbg_We = 1'b1; Dbg_Addr = 5'd12; Dbg_WData = 32'h2222;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk("starve_stall", 32'(Stall), 32'd0);
      chk("starve_wreg", 32'(WriteRegister), 32'd11);
      @(negedge Clk);
    end
    WB_WriteRegister = 5'd13; WB_WriteData = 32'h3333; #1;
    chk("forced_stall", 32'(Stall), 32'd1);
    chk("forced_wreg", 32'(WriteRegister), 32'd12);
    chk("forced_wdata", WriteData, 32'h2222);
    @(negedge Clk); #1;
    chk("forced_ack", 32'(Dbg_Ack), 32'd1);
    chk("forced_stall_drop", 32'(Stall), 32'd0);
    chk("forced_wb_wreg", 32'(WriteRegister), 32'd13);
    chk("forced_wb_wdata", WriteData, 32'h3333);
    Dbg_Req = 1'b0;
    @(negedge Clk);
    WB_RegWrite = 1'b0; ID_ReadRegister2 = 5'd12; #1;
    chk("rd_reg12", ReadData2, 32'h2222);
    ID_ReadRegister2 = 5'd13; #1;
    chk("rd_reg13", ReadData2, 32'h3333);

    // Clear_Start beats a same-cycle eligible debug write.
    @(negedge Clk);
    Clear_Start = 1'b1;
    Dbg_Req = 1'b1; Dbg_We = 1'b1; Dbg_Addr = 5'd20; Dbg_WData = 32'h5555; #1;
    chk("clrstart_no_grant", 32'(RegWrite), 32'd0);
    @(negedge Clk);
    Clear_Start = 1'b0; Dbg_Req = 1'b0; #1;
    chk("clrstart_stall", 32'(Stall), 32'd1);
    chk("clrstart_idx0", 32'(WriteRegister), 32'd0);
    chk("clrstart_no_ack", 32'(Dbg_Ack), 32'd0);
    repeat (32) @(negedge Clk);
    #1;
    chk("reclear_done", 32'(Clear_Done), 32'd1);
    for (int r = 8; r <= 25; r++) begin
      ID_ReadRegister2 = 5'(r); #1;
      chk("reclear_rd", ReadData2, 32'd0);
    end

    // Reset mid-clear at index 15 restarts from index 0.
    @(negedge Clk);
    Clear_Start = 1'b1;
    @(negedge Clk);
    Clear_Start = 1'b0;
    repeat (15) @(negedge Clk);
    #1;
    chk("midclr_idx15", 32'(WriteRegister), 32'd15);
    Rst_n = 1'b0; #1;
    chk("midrst_wreg", 32'(WriteRegister), 32'd0);
    chk("midrst_we_stall", {30'd0, RegWrite, Stall}, 32'd3);
    chk("midrst_clear_done", 32'(Clear_Done), 32'd0);
    chk("midrst_rdata", Dbg_RData, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1; #1;
    chk("restart_idx0", 32'(WriteRegister), 32'd0);
    @(negedge Clk); #1;
    chk("restart_idx1", 32'(WriteRegister), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
